// File: rtl/accum_adder_tree_pkg.sv
// accum_adder_tree_pkg: shared sizing for the 28-lane product adder tree and beat accumulator.
// Level g of the tree carries lvl_cnt(g) operands of PROD_W+g bits, packed at lvl_off(g) of one flat bus.
package accum_adder_tree_pkg;
   localparam int LANES       = 28;
   localparam int PROD_W      = 26;
   localparam int NUM_BEATS   = 28;
   localparam int ACC_W       = 36;
   localparam int TREE_LEVELS = 5;
   localparam int TREE_W      = PROD_W + TREE_LEVELS;
   localparam int CNT_W       = 5;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic [CNT_W-1:0] cnt_t;
   function automatic int lvl_cnt(input int lvl);
      int c;
      c = LANES;
      for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
      return c;
   endfunction
   function automatic int lvl_off(input int lvl);
      int o;
      o = 0;
      for (int i = 0; i < lvl; i++) o += lvl_cnt(i) * (PROD_W + i);
      return o;
   endfunction
   localparam int BUS_W = lvl_off(TREE_LEVELS) + TREE_W;
endpackage

// File: rtl/accum_adder_tree_level.sv
// tree_adder_level: one registered level of the signed adder tree with its valid bit.
// Operands are added pairwise; an unpaired last operand passes through sign-extended.
module tree_adder_level
   import accum_adder_tree_pkg::*;
#(
   parameter  int IN_CNT  = 2,
   parameter  int IN_W    = 8,
   localparam int OUT_CNT = (IN_CNT + 1) / 2,
   localparam int OUT_W   = IN_W + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     valid_i,
   input  logic [IN_CNT*IN_W-1:0]   data_i,
   output logic                     valid_o,
   output logic [OUT_CNT*OUT_W-1:0] data_o
);
   logic [OUT_CNT*OUT_W-1:0] data_d, data_q;
   logic valid_q;
   for (genvar k = 0; k < OUT_CNT; k++) begin : g_pair
      logic [IN_W-1:0] a;
      assign a = data_i[2*k*IN_W +: IN_W];
      if (2*k + 1 < IN_CNT) begin : g_add
         logic [IN_W-1:0] b;
         assign b = data_i[(2*k+1)*IN_W +: IN_W];
         assign data_d[k*OUT_W +: OUT_W] = {a[IN_W-1], a} + {b[IN_W-1], b};
      end else begin : g_pass
         assign data_d[k*OUT_W +: OUT_W] = {a[IN_W-1], a};
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_i & ~flush_i;
      end
   end
   assign data_o  = data_q;
   assign valid_o = valid_q;
endmodule

// File: rtl/accum_adder_tree.sv
// accum_adder_tree: 5-level registered adder tree over 28 signed products, then a
// NUM_BEATS-beat accumulator producing one neuron pre-activation sum with a one-cycle OutValid.
module accum_adder_tree
   import accum_adder_tree_pkg::*;
(
   input  logic                    clk,
   input  logic                    GlobalReset,
   input  logic [LANES*PROD_W-1:0] Product_syn,
   input  logic                    InValid,
   input  logic                    ClearAcc,
   output logic [ACC_W-1:0]        NeuronSum,
   output logic                    OutValid,
   output logic [CNT_W-1:0]        BeatCount
);
   logic [BUS_W-1:0] bus;
   logic [TREE_LEVELS:0] vld;
   logic [TREE_W-1:0] tree_raw;
   acc_t tree, sum, acc_d, acc_q, nsum_d, nsum_q;
   cnt_t cnt_d, cnt_q;
   logic tv, last, ov_d, ov_q;
   assign bus[0 +: LANES*PROD_W] = Product_syn;
   assign vld[0] = InValid;
   // ClearAcc flushes every level's valid, so beats in flight and a concurrent beat are dropped.
   for (genvar g = 0; g < TREE_LEVELS; g++) begin : g_lvl
      tree_adder_level #(.IN_CNT(lvl_cnt(g)), .IN_W(PROD_W + g)) u_lvl (
         .clk     (clk),
         .rst     (GlobalReset),
         .flush_i (ClearAcc),
         .valid_i (vld[g]),
         .data_i  (bus[lvl_off(g) +: lvl_cnt(g)*(PROD_W+g)]),
         .valid_o (vld[g+1]),
         .data_o  (bus[lvl_off(g+1) +: lvl_cnt(g+1)*(PROD_W+g+1)])
      );
   end
   assign tree_raw = bus[lvl_off(TREE_LEVELS) +: TREE_W];
   assign tree     = {{(ACC_W-TREE_W){tree_raw[TREE_W-1]}}, tree_raw};
   assign tv       = vld[TREE_LEVELS];
   always_comb begin
      last   = cnt_q == cnt_t'(NUM_BEATS - 1);
      sum    = acc_q + tree;
      ov_d   = tv && last && !ClearAcc;
      acc_d  = ClearAcc || (tv && last) ? '0 : !tv ? acc_q : cnt_q == '0 ? tree : sum;
      cnt_d  = ClearAcc || (tv && last) ? '0 : tv ? cnt_q + 1'b1 : cnt_q;
      nsum_d = ov_d ? sum : nsum_q;
   end
   always_ff @(posedge clk or posedge GlobalReset) begin
      if (GlobalReset) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         nsum_q <= '0;
         ov_q   <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         nsum_q <= nsum_d;
         ov_q   <= ov_d;
      end
   end
   assign NeuronSum = nsum_q;
   assign OutValid  = ov_q;
   assign BeatCount = cnt_q;
endmodule

// File: tb/tb_accum_adder_tree.sv
// tb_accum_adder_tree: random and directed beats against a lane-sum reference model;
// expected neuron sums and their arrival cycle go through a scoreboard checked by a monitor.
module tb_accum_adder_tree;
   import accum_adder_tree_pkg::*;
   logic clk = 1'b0, GlobalReset = 1'b1, InValid = 1'b0, ClearAcc = 1'b0;
   logic [LANES*PROD_W-1:0] Product_syn = '0;
   logic signed [ACC_W-1:0] NeuronSum;
   logic OutValid;
   logic [CNT_W-1:0] BeatCount;
   typedef struct { logic signed [ACC_W-1:0] sum; int cyc; } exp_t;
   exp_t sb[$];
   int tests = 0, fails = 0, cyc = 0, m_cnt = 0;
   longint m_acc = 0;
   logic signed [PROD_W-1:0] ln [LANES];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   accum_adder_tree dut (
      .clk         (clk),
      .GlobalReset (GlobalReset),
      .Product_syn (Product_syn),
      .InValid     (InValid),
      .ClearAcc    (ClearAcc),
      .NeuronSum   (NeuronSum),
      .OutValid    (OutValid),
      .BeatCount   (BeatCount)
   );
   task automatic check(input string name, input longint got, input longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (!GlobalReset && OutValid) begin
         if (sb.size() == 0) check("unexpected OutValid", 1, 0);
         else begin
            e = sb.pop_front();
            check("NeuronSum", NeuronSum, e.sum);
            check("OutValid cycle", cyc, e.cyc);
         end
      end
   end
   // Model: a beat contributes the plain sum of its lanes; every NUM_BEATS accepted beats make
   // one neuron, visible 6 cycles after the edge that launched its last beat.
   task automatic issue(input bit v, input bit clr);
      longint s;
      exp_t e;
      @(posedge clk);
      #1;
      for (int k = 0; k < LANES; k++) Product_syn[k*PROD_W +: PROD_W] = ln[k];
      InValid  = v;
      ClearAcc = clr;
      if (clr) begin
         m_acc = 0;
         m_cnt = 0;
      end else if (v) begin
         s = 0;
         for (int k = 0; k < LANES; k++) s += longint'(ln[k]);
         m_acc += s;
         m_cnt++;
         if (m_cnt == NUM_BEATS) begin
            e.sum = ACC_W'(m_acc);
            e.cyc = cyc + 6;
            sb.push_back(e);
            m_acc = 0;
            m_cnt = 0;
         end
      end
   endtask
   task automatic idle(input int n);
      repeat (n) issue(1'b0, 1'b0);
   endtask
   task automatic set_const(input longint v);
      for (int k = 0; k < LANES; k++) ln[k] = PROD_W'(v);
   endtask
   task automatic set_rand();
      for (int k = 0; k < LANES; k++) ln[k] = PROD_W'($urandom);
   endtask
   task automatic rand_beats(input int n);
      repeat (n) begin
         set_rand();
         issue(1'b1, 1'b0);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      int sent;
      repeat (2) @(negedge clk);
      check("reset NeuronSum", NeuronSum, 0);
      check("reset OutValid", OutValid, 0);
      check("reset BeatCount", BeatCount, 0);
      GlobalReset = 1'b0;
      set_const(1);
      repeat (NUM_BEATS) issue(1'b1, 1'b0);
      idle(8);
      for (int k = 0; k < LANES; k++) ln[k] = PROD_W'(-(k + 1));
      repeat (NUM_BEATS) issue(1'b1, 1'b0);
      idle(8);
      set_const(-33554432);
      repeat (NUM_BEATS) issue(1'b1, 1'b0);
      idle(8);
      set_const(1);
      repeat (10) begin
         issue(1'b1, 1'b0);
         issue(1'b0, 1'b0);
      end
      idle(7);
      check("BeatCount held in gaps", BeatCount, 10);
      repeat (18) begin
         issue(1'b1, 1'b0);
         issue(1'b0, 1'b0);
      end
      idle(8);
      set_const(1);
      repeat (NUM_BEATS) issue(1'b1, 1'b0);
      set_const(2);
      repeat (NUM_BEATS) issue(1'b1, 1'b0);
      idle(8);
      rand_beats(10);
      idle(7);
      check("BeatCount before clear", BeatCount, 10);
      set_rand();
      issue(1'b1, 1'b1);
      idle(7);
      check("BeatCount after clear", BeatCount, 0);
      rand_beats(NUM_BEATS);
      idle(8);
      rand_beats(13);
      idle(7);
      check("BeatCount before reset", BeatCount, 13);
      #1 GlobalReset = 1'b1;
      #1;
      check("async reset NeuronSum", NeuronSum, 0);
      check("async reset BeatCount", BeatCount, 0);
      check("async reset OutValid", OutValid, 0);
      m_acc = 0;
      m_cnt = 0;
      @(negedge clk);
      GlobalReset = 1'b0;
      rand_beats(NUM_BEATS);
      idle(8);
      sent = 0;
      while (sent < 4 * NUM_BEATS) begin
         set_rand();
         if ($urandom_range(0, 2) != 0) begin
            issue(1'b1, 1'b0);
            sent++;
         end else issue(1'b0, 1'b0);
      end
      idle(10);
      check("scoreboard drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
